// File: rtl/wb_retire_if.sv
// Handshake and bus bundle for the writeback retire queue: enqueue port, regfile
// write port, CSR commit port, forwarding lookups, occupancy and trace outputs.
interface wb_retire_if #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_result;
  logic            in_gr_we;
  logic [4:0]      in_dest;
  logic            in_csr_rd_we;
  logic [13:0]     in_csr_num;
  logic            in_csr_we;
  logic [XLEN-1:0] in_csr_wvalue;
  logic [XLEN-1:0] in_csr_wmask;
  logic            in_ex;
  logic [5:0]      in_ecode;
  logic [8:0]      in_esubcode;
  logic [XLEN-1:0] in_badv;
  logic            in_ertn;

  logic            rf_ready;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  logic [13:0]     csr_num;
  logic [XLEN-1:0] csr_rd_value;
  logic            csr_we;
  logic [XLEN-1:0] csr_wvalue;
  logic [XLEN-1:0] csr_wmask;
  logic            csr_ex;
  logic [5:0]      csr_ecode;
  logic [8:0]      csr_esubcode;
  logic [XLEN-1:0] csr_pc;
  logic [XLEN-1:0] csr_badv;
  logic            csr_ertn;
  logic            flush;

  logic [4:0]      fwd_raddr0;
  logic [4:0]      fwd_raddr1;
  logic            fwd_hit0;
  logic            fwd_hit1;
  logic            fwd_pending0;
  logic            fwd_pending1;
  logic [XLEN-1:0] fwd_data0;
  logic [XLEN-1:0] fwd_data1;

  logic [CW-1:0]   count;
  logic [XLEN-1:0] debug_wb_pc;
  logic [3:0]      debug_wb_rf_we;
  logic [4:0]      debug_wb_rf_wnum;
  logic [XLEN-1:0] debug_wb_rf_wdata;

  modport slave (
    input  in_valid, in_pc, in_result, in_gr_we, in_dest, in_csr_rd_we, in_csr_num,
           in_csr_we, in_csr_wvalue, in_csr_wmask, in_ex, in_ecode, in_esubcode,
           in_badv, in_ertn, rf_ready, csr_rd_value, fwd_raddr0, fwd_raddr1,
    output in_ready, rf_we, rf_waddr, rf_wdata, csr_num, csr_we, csr_wvalue, csr_wmask,
           csr_ex, csr_ecode, csr_esubcode, csr_pc, csr_badv, csr_ertn, flush,
           fwd_hit0, fwd_hit1, fwd_pending0, fwd_pending1, fwd_data0, fwd_data1,
           count, debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  modport master (
    output in_valid, in_pc, in_result, in_gr_we, in_dest, in_csr_rd_we, in_csr_num,
           in_csr_we, in_csr_wvalue, in_csr_wmask, in_ex, in_ecode, in_esubcode,
           in_badv, in_ertn, rf_ready, csr_rd_value, fwd_raddr0, fwd_raddr1,
    input  in_ready, rf_we, rf_waddr, rf_wdata, csr_num, csr_we, csr_wvalue, csr_wmask,
           csr_ex, csr_ecode, csr_esubcode, csr_pc, csr_badv, csr_ertn, flush,
           fwd_hit0, fwd_hit1, fwd_pending0, fwd_pending1, fwd_data0, fwd_data1,
           count, debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
  );
endinterface

// File: rtl/wb_retire_queue.sv
// In-order writeback queue: retires one instruction per cycle into the regfile,
// commits CSR writes / exceptions / ertn, and forwards queued results to decode.
module wb_retire_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic      clk,
  input  logic      reset,
  wb_retire_if.slave wb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] result;
    logic            gr_we;
    logic [4:0]      dest;
    logic            csr_rd_we;
    logic [13:0]     csr_num;
    logic            csr_we;
    logic [XLEN-1:0] csr_wvalue;
    logic [XLEN-1:0] csr_wmask;
    logic            ex;
    logic [5:0]      ecode;
    logic [8:0]      esubcode;
    logic [XLEN-1:0] badv;
    logic            ertn;
  } entry_t;

  typedef struct packed {
    logic            hit;
    logic            pending;
    logic [XLEN-1:0] data;
  } fwd_t;

  // Storage is data only; occupancy lives in head/count, which are reset.
  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  entry_t          hd;
  entry_t          in_entry;
  logic            head_valid;
  logic            head_wr;
  logic [XLEN-1:0] head_data;
  logic            retire;
  logic            enq;
  logic            ex_commit;
  logic            ertn_commit;
  logic            flush_c;
  fwd_t            f0;
  fwd_t            f1;

  function automatic logic writes_gpr(input entry_t e);
    return (e.gr_we | e.csr_rd_we) & ~e.ex;
  endfunction

  // Youngest-first match; a CSR read only has data once it reaches head.
  function automatic fwd_t fwd_lookup(input logic [4:0] raddr);
    fwd_t          r;
    entry_t        e;
    logic [PW-1:0] idx;
    r = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      e   = mem[idx];
      if ((CW'(k) < count) && writes_gpr(e) && (e.dest == raddr) && (raddr != 5'd0)) begin
        r.hit     = 1'b1;
        r.pending = e.csr_rd_we && (k != 0);
        if (e.csr_rd_we)
          r.data = (k == 0) ? wb.csr_rd_value : '0;
        else
          r.data = e.result;
      end
    end
    return r;
  endfunction

  always_comb begin
    in_entry = '{pc: wb.in_pc, result: wb.in_result, gr_we: wb.in_gr_we,
                 dest: wb.in_dest, csr_rd_we: wb.in_csr_rd_we, csr_num: wb.in_csr_num,
                 csr_we: wb.in_csr_we, csr_wvalue: wb.in_csr_wvalue,
                 csr_wmask: wb.in_csr_wmask, ex: wb.in_ex, ecode: wb.in_ecode,
                 esubcode: wb.in_esubcode, badv: wb.in_badv, ertn: wb.in_ertn};
    hd          = mem[head];
    head_valid  = (count != '0);
    head_wr     = writes_gpr(hd);
    head_data   = hd.csr_rd_we ? wb.csr_rd_value : hd.result;
    retire      = head_valid && !reset && (hd.ex || hd.ertn || !head_wr || wb.rf_ready);
    ex_commit   = retire && hd.ex;
    ertn_commit = retire && hd.ertn && !hd.ex;
    flush_c     = ex_commit || ertn_commit;
    enq         = wb.in_valid && (count < DEPTH_C) && !flush_c;
    f0          = fwd_lookup(wb.fwd_raddr0);
    f1          = fwd_lookup(wb.fwd_raddr1);
  end

  // Head fields are masked when empty so nothing stale leaks onto the buses.
  assign wb.in_ready     = (count < DEPTH_C);
  assign wb.count        = count;
  assign wb.rf_we        = retire && head_wr;
  assign wb.rf_waddr     = head_valid ? hd.dest : 5'd0;
  assign wb.rf_wdata     = head_valid ? head_data : '0;
  assign wb.csr_num      = head_valid ? hd.csr_num : 14'd0;
  assign wb.csr_we       = retire && hd.csr_we && !hd.ex;
  assign wb.csr_wvalue   = head_valid ? hd.csr_wvalue : '0;
  assign wb.csr_wmask    = head_valid ? hd.csr_wmask : '0;
  assign wb.csr_ex       = ex_commit;
  assign wb.csr_ecode    = head_valid ? hd.ecode : 6'd0;
  assign wb.csr_esubcode = head_valid ? hd.esubcode : 9'd0;
  assign wb.csr_pc       = head_valid ? hd.pc : '0;
  assign wb.csr_badv     = head_valid ? hd.badv : '0;
  assign wb.csr_ertn     = ertn_commit;
  assign wb.flush        = flush_c;

  assign wb.fwd_hit0     = f0.hit;
  assign wb.fwd_pending0 = f0.pending;
  assign wb.fwd_data0    = f0.data;
  assign wb.fwd_hit1     = f1.hit;
  assign wb.fwd_pending1 = f1.pending;
  assign wb.fwd_data1    = f1.data;

  assign wb.debug_wb_pc       = head_valid ? hd.pc : '0;
  assign wb.debug_wb_rf_we    = {4{retire && head_wr}};
  assign wb.debug_wb_rf_wnum  = head_valid ? hd.dest : 5'd0;
  assign wb.debug_wb_rf_wdata = head_valid ? head_data : '0;

  always_ff @(posedge clk) begin
    if (enq)
      mem[tail] <= in_entry;
  end

  always_ff @(posedge clk) begin
    if (reset || flush_c) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)
        tail <= tail + 1'b1;
      if (retire)
        head <= head + 1'b1;
      count <= count + CW'(enq) - CW'(retire);
    end
  end
endmodule

// File: tb/tb_wb_retire_queue.sv
// Bench for wb_retire_queue: directed scenarios with literal expectations plus a
// long random run, all checked every cycle against a queue-based reference model.
module tb_wb_retire_queue;
  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic        gr_we;
    logic [4:0]  dest;
    logic        csr_rd_we;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] wv;
    logic [31:0] wm;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] badv;
    logic        ertn;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  ent_t m[$];

  wb_retire_if #(.DEPTH(DEPTH), .XLEN(XLEN)) wb ();
  wb_retire_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (.clk(clk), .reset(reset), .wb(wb.slave));

  always #5 clk = ~clk;

  function automatic logic [31:0] csr_val(input logic [13:0] num);
    return (num == 14'h5) ? 32'h1234 : {2'b10, num, 16'hC5A0};
  endfunction

  assign wb.csr_rd_value = csr_val(wb.csr_num);

  function automatic logic wr_of(input ent_t e);
    return (e.gr_we | e.csr_rd_we) & ~e.ex;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic put(input ent_t e, input logic v);
    wb.in_valid = v;       wb.in_pc = e.pc;           wb.in_result = e.result;
    wb.in_gr_we = e.gr_we; wb.in_dest = e.dest;       wb.in_csr_rd_we = e.csr_rd_we;
    wb.in_csr_num = e.csr_num; wb.in_csr_we = e.csr_we; wb.in_csr_wvalue = e.wv;
    wb.in_csr_wmask = e.wm; wb.in_ex = e.ex;          wb.in_ecode = e.ecode;
    wb.in_esubcode = e.esub; wb.in_badv = e.badv;     wb.in_ertn = e.ertn;
  endtask

  function automatic ent_t alu(input logic [31:0] pc, input logic [4:0] d, input logic [31:0] v);
    ent_t e = '0;
    e.pc = pc; e.gr_we = 1'b1; e.dest = d; e.result = v;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e.pc = $urandom(); e.result = $urandom();
    e.gr_we = ($urandom_range(3) != 0);      e.dest = 5'($urandom_range(7));
    e.csr_rd_we = ($urandom_range(3) == 0);  e.csr_num = 14'($urandom_range(15));
    e.csr_we = ($urandom_range(7) == 0);     e.wv = $urandom(); e.wm = $urandom();
    e.ex = ($urandom_range(15) == 0);        e.ecode = 6'($urandom_range(63));
    e.esub = 9'($urandom_range(511));        e.badv = $urandom();
    e.ertn = ($urandom_range(31) == 0);
    return e;
  endfunction

  task automatic fwd_model(input logic [4:0] ra, output logic hit, output logic pend,
                           output logic [31:0] data);
    hit = 1'b0; pend = 1'b0; data = '0;
    for (int i = m.size() - 1; i >= 0; i--) begin
      if (!hit && wr_of(m[i]) && m[i].dest == ra && ra != 5'd0) begin
        hit  = 1'b1;
        pend = m[i].csr_rd_we && (i != 0);
        data = m[i].csr_rd_we ? ((i == 0) ? csr_val(m[i].csr_num) : 32'd0) : m[i].result;
      end
    end
  endtask

  // Reference model: compare mid-cycle, then advance the model at the edge.
  initial begin
    ent_t h, ine;
    logic rs, hv, hw, ret, ex_c, ertn_c, fl, enq;
    logic hit, pend;
    logic [31:0] data, hdata;
    @(posedge clk);
    forever begin
      @(negedge clk);
      #2;
      rs = reset;
      hv = (m.size() > 0);
      h  = hv ? m[0] : '0;
      hw = hv && wr_of(h);
      hdata  = h.csr_rd_we ? csr_val(h.csr_num) : h.result;
      ret    = hv && !rs && (h.ex || h.ertn || !wr_of(h) || wb.rf_ready);
      ex_c   = ret && h.ex;
      ertn_c = ret && h.ertn && !h.ex;
      fl     = ex_c || ertn_c;
      enq    = wb.in_valid && (m.size() < DEPTH) && !fl;
      chk("in_ready", 32'(wb.in_ready), 32'(m.size() < DEPTH));
      chk("count", 32'(wb.count), 32'(m.size()));
      chk("rf_we", 32'(wb.rf_we), 32'(ret && hw));
      chk("rf_waddr", 32'(wb.rf_waddr), 32'(h.dest));
      chk("rf_wdata", wb.rf_wdata, hv ? hdata : 32'd0);
      chk("csr_num", 32'(wb.csr_num), 32'(h.csr_num));
      chk("csr_we", 32'(wb.csr_we), 32'(ret && h.csr_we && !h.ex));
      chk("csr_wvalue", wb.csr_wvalue, h.wv);
      chk("csr_wmask", wb.csr_wmask, h.wm);
      chk("csr_ex", 32'(wb.csr_ex), 32'(ex_c));
      chk("csr_ecode", 32'(wb.csr_ecode), 32'(h.ecode));
      chk("csr_esubcode", 32'(wb.csr_esubcode), 32'(h.esub));
      chk("csr_pc", wb.csr_pc, h.pc);
      chk("csr_badv", wb.csr_badv, h.badv);
      chk("csr_ertn", 32'(wb.csr_ertn), 32'(ertn_c));
      chk("flush", 32'(wb.flush), 32'(fl));
      chk("debug_wb_pc", wb.debug_wb_pc, h.pc);
      chk("debug_wb_rf_we", 32'(wb.debug_wb_rf_we), (ret && hw) ? 32'hF : 32'h0);
      chk("debug_wb_rf_wnum", 32'(wb.debug_wb_rf_wnum), 32'(h.dest));
      chk("debug_wb_rf_wdata", wb.debug_wb_rf_wdata, hv ? hdata : 32'd0);
      fwd_model(wb.fwd_raddr0, hit, pend, data);
      chk("fwd_hit0", 32'(wb.fwd_hit0), 32'(hit));
      chk("fwd_pending0", 32'(wb.fwd_pending0), 32'(pend));
      chk("fwd_data0", wb.fwd_data0, data);
      fwd_model(wb.fwd_raddr1, hit, pend, data);
      chk("fwd_hit1", 32'(wb.fwd_hit1), 32'(hit));
      chk("fwd_pending1", 32'(wb.fwd_pending1), 32'(pend));
      chk("fwd_data1", wb.fwd_data1, data);
      ine = '{pc: wb.in_pc, result: wb.in_result, gr_we: wb.in_gr_we, dest: wb.in_dest,
              csr_rd_we: wb.in_csr_rd_we, csr_num: wb.in_csr_num, csr_we: wb.in_csr_we,
              wv: wb.in_csr_wvalue, wm: wb.in_csr_wmask, ex: wb.in_ex, ecode: wb.in_ecode,
              esub: wb.in_esubcode, badv: wb.in_badv, ertn: wb.in_ertn};
      @(posedge clk);
      if (rs || fl) m.delete();
      else begin
        if (ret) void'(m.pop_front());
        if (enq) m.push_back(ine);
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    ent_t e;
    reset = 1'b1; put('0, 1'b0); wb.rf_ready = 1'b0; wb.fwd_raddr0 = '0; wb.fwd_raddr1 = '0;
    repeat (2) nxt();
    reset = 1'b0;
    settle();
    chk("reset count", 32'(wb.count), 32'd0);
    chk("reset in_ready", 32'(wb.in_ready), 32'd1);
    chk("reset rf_we", 32'(wb.rf_we), 32'd0);
    chk("reset flush", 32'(wb.flush), 32'd0);
    chk("reset csr_num", 32'(wb.csr_num), 32'd0);

    // back-to-back ALU writes
    nxt(); wb.rf_ready = 1'b1; put(alu(32'h1c000000, 5'd1, 32'h11), 1'b1);
    nxt(); put(alu(32'h1c000004, 5'd2, 32'h22), 1'b1); settle();
    chk("b2b rf_we 1", 32'(wb.rf_we), 32'd1);
    chk("b2b trace 0x11", wb.debug_wb_rf_wdata, 32'h11);
    chk("b2b count 1", 32'(wb.count), 32'd1);
    nxt(); put('0, 1'b0); settle();
    chk("b2b trace 0x22", wb.debug_wb_rf_wdata, 32'h22);
    chk("b2b waddr 2", 32'(wb.rf_waddr), 32'd2);
    chk("b2b count 2nd", 32'(wb.count), 32'd1);

    // back-pressure on a full queue
    nxt(); wb.rf_ready = 1'b0; put(alu(32'h100, 5'd3, 32'h33), 1'b1);
    nxt(); put(alu(32'h104, 5'd6, 32'h66), 1'b1); settle();
    chk("stall rf_we", 32'(wb.rf_we), 32'd0);
    nxt(); put(alu(32'h108, 5'd7, 32'h77), 1'b1); settle();
    chk("full count", 32'(wb.count), 32'd2);
    chk("full in_ready", 32'(wb.in_ready), 32'd0);
    nxt(); wb.rf_ready = 1'b1; settle();
    chk("drain 0x33", wb.rf_wdata, 32'h33);
    nxt(); settle();
    chk("drain 0x66", wb.rf_wdata, 32'h66);
    chk("accept third", 32'(wb.in_ready), 32'd1);
    nxt(); put('0, 1'b0); settle();
    chk("drain 0x77", wb.rf_wdata, 32'h77);

    // youngest-match forwarding
    nxt(); wb.rf_ready = 1'b0; put(alu(32'h200, 5'd5, 32'hA), 1'b1);
    nxt(); put(alu(32'h204, 5'd5, 32'hB), 1'b1);
    nxt(); put('0, 1'b0); wb.fwd_raddr0 = 5'd5; wb.fwd_raddr1 = 5'd0; settle();
    chk("fwd youngest hit", 32'(wb.fwd_hit0), 32'd1);
    chk("fwd youngest data", wb.fwd_data0, 32'hB);
    chk("fwd r0 no hit", 32'(wb.fwd_hit1), 32'd0);
    nxt(); wb.rf_ready = 1'b1;
    nxt(); nxt();

    // csrrd behind a stalled entry
    nxt(); wb.rf_ready = 1'b0; put(alu(32'h300, 5'd7, 32'h70), 1'b1);
    e = '0; e.pc = 32'h304; e.csr_rd_we = 1'b1; e.dest = 5'd4; e.csr_num = 14'h5;
    nxt(); put(e, 1'b1);
    nxt(); put('0, 1'b0); wb.fwd_raddr0 = 5'd4; wb.fwd_raddr1 = 5'd7; settle();
    chk("csrrd pending", 32'(wb.fwd_pending0), 32'd1);
    chk("csrrd data 0", wb.fwd_data0, 32'd0);
    chk("older fwd data", wb.fwd_data1, 32'h70);
    nxt(); wb.rf_ready = 1'b1;
    nxt(); wb.rf_ready = 1'b0; settle();
    chk("csrrd head pending", 32'(wb.fwd_pending0), 32'd0);
    chk("csrrd head fwd", wb.fwd_data0, 32'h1234);
    chk("csrrd head wdata", wb.rf_wdata, 32'h1234);
    nxt(); wb.rf_ready = 1'b1; settle();
    chk("csrrd retire", 32'(wb.rf_we), 32'd1);
    nxt(); wb.fwd_raddr0 = '0; wb.fwd_raddr1 = '0;

    // exception at head with rf_ready low, younger entries dropped
    nxt(); wb.rf_ready = 1'b0; put(alu(32'h400, 5'd10, 32'h10), 1'b1);
    e = '0; e.pc = 32'h1c000100; e.ex = 1'b1; e.ecode = 6'hB; e.gr_we = 1'b1; e.dest = 5'd8;
    nxt(); put(e, 1'b1);
    nxt(); put(alu(32'h408, 5'd11, 32'h11), 1'b1); wb.rf_ready = 1'b1;
    nxt(); wb.rf_ready = 1'b0; settle();
    chk("ex csr_ex", 32'(wb.csr_ex), 32'd1);
    chk("ex flush", 32'(wb.flush), 32'd1);
    chk("ex rf_we", 32'(wb.rf_we), 32'd0);
    chk("ex ecode", 32'(wb.csr_ecode), 32'hB);
    chk("ex pc", wb.csr_pc, 32'h1c000100);
    nxt(); put('0, 1'b0); settle();
    chk("ex emptied", 32'(wb.count), 32'd0);

    // csrwr commits only at retire, then ertn
    nxt(); put(alu(32'h500, 5'd12, 32'h12), 1'b1);
    e = '0; e.pc = 32'h504; e.csr_we = 1'b1; e.csr_num = 14'h6; e.wv = 32'hCAFE0000; e.wm = 32'hFF;
    nxt(); put(e, 1'b1);
    nxt(); put('0, 1'b0); settle();
    chk("csrwr held", 32'(wb.csr_we), 32'd0);
    nxt(); wb.rf_ready = 1'b1;
    nxt(); e = '0; e.pc = 32'h508; e.ertn = 1'b1; put(e, 1'b1); settle();
    chk("csrwr commit", 32'(wb.csr_we), 32'd1);
    chk("csrwr mask", wb.csr_wmask, 32'hFF);
    chk("csrwr value", wb.csr_wvalue, 32'hCAFE0000);
    nxt(); put('0, 1'b0); settle();
    chk("ertn commit", 32'(wb.csr_ertn), 32'd1);
    chk("ertn flush", 32'(wb.flush), 32'd1);
    chk("ertn csr_we", 32'(wb.csr_we), 32'd0);

    // reset mid-operation
    nxt(); wb.rf_ready = 1'b0; put(alu(32'h600, 5'd13, 32'h13), 1'b1);
    nxt(); put(alu(32'h604, 5'd14, 32'h14), 1'b1);
    nxt(); put('0, 1'b0); reset = 1'b1; wb.rf_ready = 1'b1; settle();
    chk("reset no retire", 32'(wb.rf_we), 32'd0);
    nxt(); reset = 1'b0; settle();
    chk("reset emptied", 32'(wb.count), 32'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      nxt();
      reset = ($urandom_range(199) == 0);
      wb.rf_ready = ($urandom_range(9) < 6);
      put(rnd_ent(), $urandom_range(9) < 7);
      wb.fwd_raddr0 = 5'($urandom_range(7));
      wb.fwd_raddr1 = 5'($urandom_range(7));
    end
    nxt(); reset = 1'b0; put('0, 1'b0);
    nxt(); #4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_retire_queue.md
# wb_retire_queue

Parametrised writeback stage that sits between the memory stage and the register file / CSR unit of the LoongArch pipeline. It buffers up to DEPTH completed instructions in program order and retires one per cycle when the shared regfile write port is granted. It resolves CSR-read results at retire, commits CSR writes, exceptions and ertn, and raises a pipeline flush. It also supplies youngest-match forwarding for two decode read ports.

## Interface
- DEPTH, 2, queue entries; power of two, minimum 2
- XLEN, 32, datapath width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid / in_ready  in / out  1 / 1  enqueue handshake from mem stage
- in_pc, in_result  in  XLEN each  instruction PC, ALU/load result
- in_gr_we, in_dest  in  1, 5  GPR write enable, destination
- in_csr_rd_we, in_csr_num  in  1, 14  CSR-read-to-GPR flag, CSR index
- in_csr_we, in_csr_wvalue, in_csr_wmask  in  1, XLEN, XLEN  CSR write request
- in_ex, in_ecode, in_esubcode, in_badv  in  1, 6, 9, XLEN  exception info
- in_ertn  in  1  ertn instruction
- rf_ready  in  1  regfile write port granted this cycle
- rf_we, rf_waddr, rf_wdata  out  1, 5, XLEN  regfile write
- csr_num  out  14  head entry CSR index, always driven
- csr_rd_value  in  XLEN  CSR read data for csr_num, combinational
- csr_we, csr_wvalue, csr_wmask  out  1, XLEN, XLEN  CSR commit
- csr_ex, csr_ecode, csr_esubcode, csr_pc, csr_badv, csr_ertn  out  1, 6, 9, XLEN, XLEN, 1  exception/ertn commit
- flush  out  1  pipeline flush
- fwd_raddr0/1  in  5  decode source registers
- fwd_hit0/1, fwd_pending0/1, fwd_data0/1  out  1, 1, XLEN  forwarding result
- count  out  $clog2(DEPTH)+1  occupied entries
- debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata  out  XLEN, 4, 5, XLEN  trace

## Operation
- Circular buffer with head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH; count tracks occupancy.
- in_ready = (count < DEPTH). No bypass, so a full queue never accepts.
- Enqueue on in_valid && in_ready && !flush. All fields are stored. An entry writes the GPR when wr = (gr_we | csr_rd_we) && !ex.
- Head data is csr_rd_value if csr_rd_we, else result. Head dest is the stored dest in both cases.
- retire = head valid && (ex || ertn || !wr || rf_ready).
- rf_we = retire && wr. rf_waddr and rf_wdata come from head. Entries with dest 0 still write; the regfile ignores r0.
- csr_we = retire && csr_we && !ex. csr_ex = retire && ex. csr_ertn = retire && ertn && !ex. The remaining csr_* fields are head fields.
- flush = csr_ex || csr_ertn. On the next edge the queue empties (count=0, head=tail=0), and any same-cycle enqueue is dropped.
- Forwarding, per port: scan valid entries from youngest to oldest, excluding entries with ex set, and take the first entry with wr && dest == raddr && raddr != 0.
  - Match found: hit=1.
  - Matched entry is a CSR read not at head: pending=1, data=0; decode must stall.
  - Otherwise: data = entry data (CSR read at head uses csr_rd_value).
  - No match: hit=0, pending=0, data=0.
- debug_wb_rf_we = {4{rf_we}}. The other debug outputs mirror head pc and the rf_waddr/rf_wdata values.

## Timing
- Reset: count=0, pointers=0, all entries invalid. Every output is 0 except in_ready=1 and csr_num=0.
- Latency: an entry enqueued at edge N is at head in cycle N+1 when the queue was empty, and can retire in that cycle.
- Throughput: one retire per cycle while rf_ready=1; enqueue and retire in the same cycle keep count unchanged.
- Retire side effects (rf_we, csr_*, flush) are combinational from head state and commit at the edge ending that cycle.
- rf_ready=0 with a wr head: head holds, count grows until full, then in_ready=0.
- An exception at head retires even with rf_ready=0.
- Reset mid-operation: the queue empties the next cycle with no retire side effects.

## Test plan
- Back-to-back ALU writes r1=0x11, r2=0x22, rf_ready=1 → rf_we in consecutive cycles, trace shows 0x11 then 0x22, count stays ≤1.
- DEPTH=2, rf_ready=0, three enqueues → third is held (in_ready=0, count=2); raising rf_ready retires in order and accepts the third.
- Two queued writes to r5 (0xA then 0xB), fwd_raddr0=5 → hit0=1, data0=0xB; fwd_raddr1=0 → hit1=0.
- csrrd r4 of CSR 0x5 behind a stalled entry → pending=1 until it reaches head, then data=csr_rd_value=0x1234, rf_wdata=0x1234.
- Exception entry (ecode 0xB, pc 0x1c000100) at head with rf_ready=0, younger entry queued, in_valid=1 → csr_ex=1, flush=1, rf_we=0, count=0 next cycle, younger and incoming entries dropped.
- ertn at head → csr_ertn=1, flush=1, csr_we=0; a csrwr with wmask 0xFF commits csr_we with that mask only when it retires.
